key_debounce: RTL

Front-end conditioning stage for the 12-key piano path. It synchronises and debounces raw mechanical key lines and reduces simultaneous presses to a single one-hot key by priority. It drives the 12-bit key vector consumed by the keypad-scan/piezo chain, plus a valid flag, an encoded key code and one-cycle press/release strobes. Runs on the 1 MHz system clock used by the tone generator.

---
 rtl/key_pkg.sv | 22 ++
 rtl/debounce_bit.sv | 48 ++++
 rtl/key_debounce.sv | 71 +++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants and priority helpers for the key conditioning path.
package key_pkg;

  localparam int unsigned N_KEYS               = 12;
  localparam int unsigned DEFAULT_DEBOUNCE_CYC = 20000;
  localparam int unsigned KEY_CODE_W           = 4;

  // Isolates the lowest set bit (two's-complement trick); zero in gives zero out.
  function automatic logic [N_KEYS-1:0] lowest_onehot(input logic [N_KEYS-1:0] v);
    return v & (~v + N_KEYS'(1));
  endfunction

  function automatic logic [KEY_CODE_W-1:0] encode(input logic [N_KEYS-1:0] onehot);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (onehot[i]) code = KEY_CODE_W'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single key line: two-flop synchroniser followed by a mismatch counter that
// only accepts a new level after DEBOUNCE_CYC consecutive disagreeing cycles.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_x,
  input  logic raw,
  output logic stable
);

  localparam int unsigned  CntW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic            q1_q, q2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter clears on agreement and on the flip, so it can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (q2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = q2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      q1_q     <= 1'b0;
      q2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q1_q     <= raw;
      q2_q     <= q1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces all key lines in parallel, keeps only the lowest-index held key,
// and registers the one-hot key, its code, a valid flag and press/release strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic [N_KEYS-1:0]     raw_keys,
  output logic [N_KEYS-1:0]     key_out,
  output logic                  valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  press_pulse,
  output logic                  release_pulse
);

  logic [N_KEYS-1:0]     stable;
  logic [N_KEYS-1:0]     sel;

  logic [N_KEYS-1:0]     key_out_q, key_out_d;
  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce_bit (
      .clk   (clk),
      .rst_x (rst_x),
      .raw   (raw_keys[k]),
      .stable(stable[k])
    );
  end

  assign sel = lowest_onehot(stable);

  // Switching between two held keys is a press of the new key, never a release.
  always_comb begin
    key_out_d  = sel;
    key_code_d = encode(sel);
    valid_d    = (sel != '0);
    press_d    = (sel != '0) && (sel != key_out_q);
    release_d  = (sel == '0) && (key_out_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      key_out_q  <= '0;
      valid_q    <= 1'b0;
      key_code_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      key_out_q  <= key_out_d;
      valid_q    <= valid_d;
      key_code_q <= key_code_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign key_out       = key_out_q;
  assign valid         = valid_q;
  assign key_code      = key_code_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
